// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and default geometry.
package dmem_pkg;

  localparam int DEF_AW = 6;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_BUSY_P = 2'd1,
    STATE_BUSY_D = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_rr_guard.sv
// Grant decision for the data-memory arbiter: P has priority unless D has been passed over STARVE times.
module dmem_rr_guard #(
  parameter int STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic p_ok,
  input  logic d_req,
  output logic p_win,
  output logic d_win
);

  localparam int CW = $clog2(STARVE + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE));

  always_comb begin
    d_win = arb_en && d_req && (!p_ok || starved);
    p_win = arb_en && p_ok && !(d_req && starved);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (d_win) begin
      starve_cnt <= '0;
    end else if (p_win && d_req && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (P) and the debug/loader port (D),
// with starvation protection for D, out-of-range guarding for P and an ack timeout.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int STARVE = 4,
  parameter int TMO    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [31:0]   p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);

  localparam int TW = $clog2(TMO + 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          p_oor;
  logic          p_ok;
  logic          p_win;
  logic          d_win;
  logic          busy;
  logic          busy_p;
  logic          tmo_hit;
  logic          p_abort;

  assign p_oor   = p_req && (p_addr[31:AW] != '0);
  assign p_ok    = p_req && !p_oor;
  assign busy    = (state == STATE_BUSY_P) || (state == STATE_BUSY_D);
  assign busy_p  = (state == STATE_BUSY_P);
  assign tmo_hit = busy && !m_ack && (tmo_cnt == TW'(TMO - 1));
  assign p_abort = busy_p && tmo_hit;

  // An aborted or out-of-range P access releases the stall with zero data, like a completed load.
  assign p_stall = p_req && !(busy_p && m_ack) && !p_oor && !p_abort;
  assign p_rdata = (p_oor || p_abort) ? '0 : m_rdata;

  dmem_rr_guard #(
    .STARVE(STARVE)
  ) u_guard (
    .clk   (clk),
    .rst   (rst),
    .arb_en(state == STATE_IDLE),
    .p_ok  (p_ok),
    .d_req (d_req),
    .p_win (p_win),
    .d_win (d_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STATE_IDLE;
      tmo_cnt <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      d_done  <= 1'b0;
      d_rdata <= '0;
      err     <= 1'b0;
    end else begin
      d_done <= 1'b0;
      if (p_oor) err <= 1'b1;
      case (state)
        STATE_IDLE: begin
          tmo_cnt <= '0;
          if (p_win) begin
            state   <= STATE_BUSY_P;
            m_req   <= 1'b1;
            m_we    <= p_we;
            m_addr  <= p_addr[AW-1:0];
            m_wdata <= p_wdata;
          end else if (d_win) begin
            state   <= STATE_BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end
        end
        STATE_BUSY_P, STATE_BUSY_D: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= STATE_IDLE;
            if (state == STATE_BUSY_D) begin
              d_done <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end
          end else if (tmo_hit) begin
            m_req <= 1'b0;
            state <= STATE_IDLE;
            err   <= 1'b1;
            if (state == STATE_BUSY_D) begin
              d_done  <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed P/D traffic against a 1-cycle-ack memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p_req = 1'b0, p_we = 1'b0;
  logic [31:0]   p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [DW-1:0] p_rdata;
  logic          p_stall;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          err;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { bit chk; logic [31:0] val; } pexp_t;
  typedef struct { logic [AW-1:0] addr; logic we; } grant_t;

  pexp_t       pq[$];
  logic [31:0] dq[$];
  grant_t      gq[$];

  // Memory model: acks one cycle after seeing m_req; word i preloaded with i*100.
  logic [DW-1:0] mem [64];
  bit            withhold = 1'b0;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i * 100);

  always @(posedge clk) begin
    if (m_req && !m_ack && !withhold) begin
      m_ack <= 1'b1;
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end else begin
      m_ack <= 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a P access, a D access, or issues a grant.
  logic   mreq_q = 1'b0;
  pexp_t  pe;
  grant_t ge;
  logic [31:0] de;

  always @(negedge clk) begin
    if (rst) begin
      if (p_req && !p_stall) begin
        if (pq.size() == 0) chk("p_unexpected_release", 32'd1, 32'd0);
        else begin
          pe = pq.pop_front();
          if (pe.chk) chk("p_rdata", p_rdata, pe.val);
        end
      end
      if (d_done) begin
        if (dq.size() == 0) chk("d_unexpected_done", 32'd1, 32'd0);
        else begin
          de = dq.pop_front();
          chk("d_rdata", d_rdata, de);
        end
      end
      if (m_req && !mreq_q) begin
        if (gq.size() == 0) chk("m_req_unexpected", 32'd1, 32'd0);
        else begin
          ge = gq.pop_front();
          chk("grant_addr", 32'(m_addr), 32'(ge.addr));
          chk("grant_we", 32'(m_we), 32'(ge.we));
        end
      end
    end
    mreq_q <= m_req;
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic p_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls);
    int n;
    p_we = we; p_addr = addr; p_wdata = wd; p_req = 1'b1;
    stalls = 0; n = 0;
    @(negedge clk);
    while (p_stall && n < 100) begin
      stalls++; n++;
      @(negedge clk);
    end
    if (p_stall) chk("p_wait_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 p_req = 1'b0;
  endtask

  int st, cnt, n;

  initial begin
    #2;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_p_stall", 32'(p_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: P load addr 2, two stall cycles, data 200
    gq.push_back('{6'd2, 1'b0});
    pq.push_back('{1'b1, 32'd200});
    p_access(1'b0, 32'd2, 32'd0, st);
    chk("t1_stall_cycles", 32'(st), 32'd2);

    // 2: store then load back
    gq.push_back('{6'd5, 1'b1});
    pq.push_back('{1'b0, 32'd0});
    p_access(1'b1, 32'd5, 32'hDEAD, st);
    gq.push_back('{6'd5, 1'b0});
    pq.push_back('{1'b1, 32'hDEAD});
    p_access(1'b0, 32'd5, 32'd0, st);

    // 3: P and D held together: P,P,P,P,D,P
    for (int k = 0; k < 4; k++) gq.push_back('{6'd3, 1'b0});
    gq.push_back('{6'd9, 1'b0});
    gq.push_back('{6'd3, 1'b0});
    for (int k = 0; k < 5; k++) pq.push_back('{1'b1, 32'd300});
    dq.push_back(32'd900);
    fork
      begin
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'd3;
        for (int k = 0; k < 5; k++) begin
          int w;
          w = 0;
          @(negedge clk);
          while (p_stall && w < 100) begin w++; @(negedge clk); end
          if (p_stall) chk("t3_p_timeout", 32'd1, 32'd0);
          @(posedge clk);
          #1;
        end
        p_req = 1'b0;
      end
      begin
        int w;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd9;
        w = 0;
        @(negedge clk);
        while (!d_done && w < 200) begin w++; @(negedge clk); end
        if (!d_done) chk("t3_d_timeout", 32'd1, 32'd0);
        d_req = 1'b0;
      end
    join
    chk("t3_err_clear", 32'(err), 32'd0);

    // 4: out-of-range P load
    pq.push_back('{1'b1, 32'd0});
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'd64;
    @(negedge clk);
    chk("t4_oor_stall", 32'(p_stall), 32'd0);
    @(posedge clk);
    #1 p_req = 1'b0;
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // 5: D read with ack withheld -> timeout after 15 BUSY cycles
    do_reset();
    chk("t5_err_after_rst", 32'(err), 32'd0);
    withhold = 1'b1;
    gq.push_back('{6'd1, 1'b0});
    dq.push_back(32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd1;
    cnt = 0; n = 0;
    @(negedge clk);
    while (!d_done && n < 100) begin
      if (m_req) cnt++;
      n++;
      @(negedge clk);
    end
    if (!d_done) chk("t5_d_timeout", 32'd1, 32'd0);
    d_req = 1'b0;
    chk("t5_busy_cycles", 32'(cnt), 32'd15);
    chk("t5_err", 32'(err), 32'd1);
    withhold = 1'b0;
    @(posedge clk); #1;

    // 6: async reset mid BUSY_P, then a fresh load
    withhold = 1'b1;
    gq.push_back('{6'd7, 1'b0});
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'd7;
    n = 0;
    @(negedge clk);
    while (!m_req && n < 20) begin n++; @(negedge clk); end
    if (!m_req) chk("t6_no_grant", 32'd1, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_m_req_async", 32'(m_req), 32'd0);
    chk("t6_state_idle", 32'(dut.state), 32'(STATE_IDLE));
    chk("t6_err_cleared", 32'(err), 32'd0);
    p_req = 1'b0;
    withhold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    gq.push_back('{6'd2, 1'b0});
    pq.push_back('{1'b1, 32'd200});
    p_access(1'b0, 32'd2, 32'd0, st);
    chk("t6_stall_cycles", 32'(st), 32'd2);

    repeat (3) @(negedge clk);
    chk("end_pq_empty", 32'(pq.size()), 32'd0);
    chk("end_dq_empty", 32'(dq.size()), 32'd0);
    chk("end_gq_empty", 32'(gq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
